// File: rtl/topk_sort_pkg.sv
// topk_sort_pkg: shared types and helpers for the topk_sort_relu block.
//   state_t  : frame FSM state (FILL collects samples, DRAIN emits the sorted list)
//   entry_t  : one sorted-array slot {valid, data, index}
//   ranks_ahead(a, b, asce) : 1 when value a must sit strictly ahead of b
// Sample widths are fixed here so the entry struct can be shared by every file.
package topk_sort_pkg;

    localparam int DATA_W = 32;  // signed sample value width
    localparam int IDX_W  = 32;  // sample index width

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic                     valid;
        logic signed [DATA_W-1:0] data;
        logic        [IDX_W-1:0]  index;
    } entry_t;

    // Strict comparison keeps ties stable: an equal newcomer never overtakes
    // an entry that arrived earlier.
    function automatic logic ranks_ahead(input logic signed [DATA_W-1:0] a,
                                         input logic signed [DATA_W-1:0] b,
                                         input logic asce);
        if (asce) begin
            return a < b;
        end
        return a > b;
    endfunction

endpackage

// File: rtl/topk_sort_cell.sv
// topk_sort_cell: one slot of the parallel compare-and-shift insertion array.
//   cur      : this slot's current entry
//   prv      : previous (head-side) slot's current entry
//   smp      : incoming sample (already ReLU-clamped when enabled)
//   asce     : effective sort direction for this sample
//   ins_prev : insertion point is at or ahead of the previous slot
//   nxt      : entry this slot takes if the sample is accepted
//   ins      : insertion point is at or ahead of this slot
module topk_sort_cell
    import topk_sort_pkg::*;
(
    input  entry_t cur,
    input  entry_t prv,
    input  entry_t smp,
    input  logic   asce,
    input  logic   ins_prev,
    output entry_t nxt,
    output logic   ins
);

    // The first empty slot or the first slot the sample outranks is the
    // insertion point; every slot behind it shifts one place toward the tail.
    assign ins = ins_prev | ~cur.valid | ranks_ahead(smp.data, cur.data, asce);

    always_comb begin
        nxt = cur;
        if (ins_prev) begin
            nxt = prv;
        end else if (ins) begin
            nxt = smp;
        end
    end

endmodule

// File: rtl/topk_sort_relu.sv
// topk_sort_relu: streaming top-K sorter with optional ReLU front end.
// Keeps the DEPTH best (value, index) samples of a frame in a sorted array,
// then drains them head first after the frame's last sample.
// Optional feature macro: TOPK_RELU_EN (clamp negative samples to 0).
// Ports:
//   clk, rst                  : clock (rising edge), async active-low reset
//   in_valid/in_ready         : input handshake; transfer when both are 1
//   in_data/in_index/in_last  : sample value, index, end-of-frame flag
//   asce                      : 1 keep smallest, 0 keep largest (latched per frame)
//   out_valid/out_ready       : output handshake; transfer when both are 1
//   out_data/out_index        : sorted entry at the head of the array
//   out_last                  : final entry of the frame
//   count                     : number of occupied entries
//   state                     : debug view of the frame FSM
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both 1; valid and its payload hold stable until that edge.
module topk_sort_relu
    import topk_sort_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic        [IDX_W-1:0]  in_index,
    input  logic                     in_last,
    input  logic                     asce,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic        [IDX_W-1:0]  out_index,
    output logic                     out_last,
    output logic        [CNT_W-1:0]  count,
    output state_t                   state
);

    entry_t     ent     [DEPTH];
    entry_t     nxt     [DEPTH];
    entry_t     prv     [DEPTH];
    logic [DEPTH:0] ins;
    entry_t     smp;
    logic       asce_q;
    logic       asce_eff;
    logic       first;

    // The direction is taken from the live input on a frame's first sample and
    // from the latch for every later sample of the same frame.
    assign first    = (count == '0);
    assign asce_eff = first ? asce : asce_q;

    always_comb begin
        smp       = '0;
        smp.valid = 1'b1;
        smp.index = in_index;
`ifdef TOPK_RELU_EN
        smp.data  = in_data[DATA_W-1] ? '0 : in_data;
`else
        smp.data  = in_data;
`endif
    end

    assign ins[0] = 1'b0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        if (i == 0) begin : g_head
            assign prv[i] = '0;
        end else begin : g_body
            assign prv[i] = ent[i-1];
        end

        topk_sort_cell u_cell (
            .cur      (ent[i]),
            .prv      (prv[i]),
            .smp      (smp),
            .asce     (asce_eff),
            .ins_prev (ins[i]),
            .nxt      (nxt[i]),
            .ins      (ins[i+1])
        );
    end

    assign in_ready  = (state == FILL);
    assign out_valid = (state == DRAIN);
    assign out_data  = out_valid ? ent[0].data  : '0;
    assign out_index = out_valid ? ent[0].index : '0;
    assign out_last  = out_valid && (count == CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FILL;
            count  <= '0;
            asce_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            ent[i] <= nxt[i];
                        end
                        // A not-full array always has an empty slot to take
                        // the sample; a full array only swaps its tail.
                        if (count != CNT_W'(DEPTH)) begin
                            count <= count + CNT_W'(1);
                        end
                        if (first) begin
                            asce_q <= asce;
                        end
                        if (in_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        for (int i = 0; i < DEPTH - 1; i++) begin
                            ent[i] <= ent[i+1];
                        end
                        ent[DEPTH-1] <= '0;
                        count        <= count - CNT_W'(1);
                        if (count == CNT_W'(1)) begin
                            state <= FILL;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_topk_sort_relu.sv
// tb_topk_sort_relu: directed bench for topk_sort_relu (DEPTH=4 and DEPTH=8
// instances). Expected ReLU results follow the TOPK_RELU_EN macro.
module tb_topk_sort_relu;
    import topk_sort_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // DEPTH = 4 instance
    logic              in_valid4 = 0, in_ready4, in_last4 = 0, asce4 = 1;
    logic signed [31:0] in_data4 = 0;
    logic [31:0]       in_index4 = 0;
    logic              out_valid4, out_ready4 = 0, out_last4;
    logic signed [31:0] out_data4;
    logic [31:0]       out_index4;
    logic [2:0]        count4;
    state_t            state4;

    // DEPTH = 8 instance
    logic              in_valid8 = 0, in_ready8, in_last8 = 0, asce8 = 1;
    logic signed [31:0] in_data8 = 0;
    logic [31:0]       in_index8 = 0;
    logic              out_valid8, out_ready8 = 0, out_last8;
    logic signed [31:0] out_data8;
    logic [31:0]       out_index8;
    logic [3:0]        count8;
    state_t            state8;

    topk_sort_relu #(.DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .in_index(in_index4), .in_last(in_last4), .asce(asce4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_index(out_index4), .out_last(out_last4), .count(count4),
        .state(state4)
    );

    topk_sort_relu #(.DEPTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .in_index(in_index8), .in_last(in_last8), .asce(asce8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_index(out_index8), .out_last(out_last8), .count(count8),
        .state(state8)
    );

    typedef struct {
        string             name;
        int                n;
        logic              asc;
        logic signed [31:0] din [8];
        logic [31:0]       idx [8];
        int                en;
        logic signed [31:0] edat[8];
        logic [31:0]       eidx[8];
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string name, input longint got, input longint exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mid-frame asce flips to the opposite value to show the latch holds.
    task automatic send4(input vec_t v);
        for (int s = 0; s < v.n; s++) begin
            in_valid4 = 1'b1;
            in_data4  = v.din[s];
            in_index4 = v.idx[s];
            in_last4  = (s == v.n - 1);
            asce4     = (s == 0) ? v.asc : ~v.asc;
            tick();
        end
        in_valid4 = 1'b0;
        in_last4  = 1'b0;
    endtask

    task automatic drain4_entry(input string name, input logic signed [31:0] ed,
                                input logic [31:0] ei, input logic el);
        int k;
        out_ready4 = 1'b1;
        k = 0;
        while (!out_valid4 && k < 50) begin
            tick();
            k++;
        end
        chk({name, " out_valid"}, out_valid4, 1);
        chk({name, " out_data"},  out_data4,  ed);
        chk({name, " out_index"}, out_index4, ei);
        chk({name, " out_last"},  out_last4,  el);
        tick();
        out_ready4 = 1'b0;
    endtask

    initial begin
        vecs[0].name = "asc4";
        vecs[0].n = 7; vecs[0].asc = 1'b1;
        vecs[0].din  = '{20, 15, 25, 5, 2, 10, 35, 0};
        vecs[0].idx  = '{0, 1, 2, 3, 4, 5, 6, 0};
        vecs[0].en = 4;
        vecs[0].edat = '{2, 5, 10, 15, 0, 0, 0, 0};
        vecs[0].eidx = '{4, 3, 5, 1, 0, 0, 0, 0};

        vecs[1].name = "desc4";
        vecs[1].n = 7; vecs[1].asc = 1'b0;
        vecs[1].din  = '{20, 15, 25, 5, 2, 10, 35, 0};
        vecs[1].idx  = '{0, 1, 2, 3, 4, 5, 6, 0};
        vecs[1].en = 4;
        vecs[1].edat = '{35, 25, 20, 15, 0, 0, 0, 0};
        vecs[1].eidx = '{6, 2, 0, 1, 0, 0, 0, 0};

        vecs[2].name = "relu4";
        vecs[2].n = 3; vecs[2].asc = 1'b0;
        vecs[2].din  = '{-3, 7, -1, 0, 0, 0, 0, 0};
        vecs[2].idx  = '{0, 1, 2, 0, 0, 0, 0, 0};
        vecs[2].en = 3;
`ifdef TOPK_RELU_EN
        vecs[2].edat = '{7, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].eidx = '{1, 0, 2, 0, 0, 0, 0, 0};
`else
        vecs[2].edat = '{7, -1, -3, 0, 0, 0, 0, 0};
        vecs[2].eidx = '{1, 2, 0, 0, 0, 0, 0, 0};
`endif

        // Reset state
        #2;
        chk("rst in_ready", in_ready4, 1);
        chk("rst out_valid", out_valid4, 0);
        chk("rst out_data", out_data4, 0);
        chk("rst out_index", out_index4, 0);
        chk("rst out_last", out_last4, 0);
        chk("rst count", count4, 0);
        chk("rst state", state4, FILL);
        chk("rst count8", count8, 0);
        #10 rst = 1'b1;
        tick();

        // Table-driven frames
        for (int t = 0; t < 3; t++) begin
            send4(vecs[t]);
            chk({vecs[t].name, " count"}, count4, (vecs[t].n < 4) ? vecs[t].n : 4);
            chk({vecs[t].name, " drain start"}, out_valid4, 1);
            chk({vecs[t].name, " in_ready drain"}, in_ready4, 0);
            for (int e = 0; e < vecs[t].en; e++) begin
                drain4_entry(vecs[t].name, vecs[t].edat[e], vecs[t].eidx[e],
                             e == vecs[t].en - 1);
            end
            chk({vecs[t].name, " in_ready back"}, in_ready4, 1);
            chk({vecs[t].name, " count end"}, count4, 0);
            chk({vecs[t].name, " out_valid end"}, out_valid4, 0);
        end

        // Backpressure: head held stable for 5 cycles, then full drain
        send4(vecs[0]);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp out_valid", out_valid4, 1);
            chk("bp out_data", out_data4, 2);
            chk("bp out_index", out_index4, 4);
            chk("bp in_ready", in_ready4, 0);
        end
        for (int e = 0; e < 4; e++) begin
            drain4_entry("bp", vecs[0].edat[e], vecs[0].eidx[e], e == 3);
        end
        chk("bp in_ready back", in_ready4, 1);

        // Short frame on DEPTH=8
        in_valid8 = 1; in_data8 = 13; in_index8 = 7; asce8 = 1; in_last8 = 0;
        tick();
        in_data8 = 11; in_index8 = 8; in_last8 = 1; asce8 = 0;
        tick();
        in_valid8 = 0; in_last8 = 0;
        chk("short count", count8, 2);
        out_ready8 = 1;
        chk("short v0", out_valid8, 1);
        chk("short d0", out_data8, 11);
        chk("short i0", out_index8, 8);
        chk("short l0", out_last8, 0);
        tick();
        chk("short d1", out_data8, 13);
        chk("short i1", out_index8, 7);
        chk("short l1", out_last8, 1);
        tick();
        out_ready8 = 0;
        chk("short in_ready", in_ready8, 1);
        chk("short count end", count8, 0);

        // Reset pulse after two of four drain handshakes
        send4(vecs[0]);
        drain4_entry("rstmid", 2, 4, 0);
        drain4_entry("rstmid", 5, 3, 0);
        rst = 1'b0;
        #2;
        chk("rstmid out_valid", out_valid4, 0);
        chk("rstmid count", count4, 0);
        chk("rstmid in_ready", in_ready4, 1);
        chk("rstmid out_last", out_last4, 0);
        #2 rst = 1'b1;
        tick();
        in_valid4 = 1; in_data4 = 9; in_index4 = 13; in_last4 = 1; asce4 = 1;
        tick();
        in_valid4 = 0; in_last4 = 0;
        chk("post rst count", count4, 1);
        drain4_entry("post rst", 9, 13, 1);
        chk("post rst in_ready", in_ready4, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/topk_sort_relu.md
# topk_sort_relu

Streaming top-K sorter with optional ReLU front end, the parametrised successor to `sort_relu`. It accepts a frame of (value, index) samples over a valid/ready handshake and keeps the DEPTH best entries in a sorted insertion array. "Best" means smallest when ascending and largest when descending. After the frame's last sample it drains the sorted list downstream. It sits between activation producers and the selection and pooling logic of the accelerator.

## Interface
- DATA_W, 32: sample value width; two's-complement signed.
- IDX_W, 32: sample index width.
- DEPTH, 8: entries kept per frame (K); must be ≥ 2.
- clk  in  1: clock, rising edge.
- rst  in  1: reset, asynchronous, active-low.
- in_valid  in  1: input sample valid.
- in_ready  out  1: block can accept a sample.
- in_data  in  DATA_W: sample value.
- in_index  in  IDX_W: sample index.
- in_last  in  1: this sample ends the frame.
- asce  in  1: 1 = ascending (keep smallest), 0 = descending (keep largest); sampled on the frame's first accepted sample.
- out_valid  out  1: output entry valid.
- out_ready  in  1: downstream accepts the entry.
- out_data  out  DATA_W: sorted value (after ReLU when enabled).
- out_index  out  IDX_W: index of that value.
- out_last  out  1: final entry of the frame.
- count  out  $clog2(DEPTH+1): number of occupied entries.

## Operation
- States:
  - FILL (reset state): in_ready = 1. An accepted sample is clamped to 0 if negative, when ReLU is enabled. It is then inserted in one cycle by parallel compare-and-shift: entries behind the insertion point move one slot toward the tail.
  - DRAIN: in_ready = 0. Entries leave from the head, one per out handshake.
- Mode latch: asce is latched when the first sample of a frame is accepted. asce changes mid-frame are ignored.
- Ordering:
  - Ascending: a new value goes ahead of the first stored entry that is strictly greater.
  - Descending: a new value goes ahead of the first stored entry that is strictly less.
  - Ties are stable; the earlier arrival stays ahead.
- Array full: if the new value ranks after every stored entry, it is discarded and count stays at DEPTH. Otherwise the tail entry is dropped.
- Frame end: accepting a sample with in_last moves FILL → DRAIN.
- out_last is asserted with the entry whose handshake empties the array.
- Leaving DRAIN: after the out_last handshake, count goes to 0 and the state returns to FILL.
- Frame length: a frame shorter than DEPTH drains only count entries. A one-sample frame drains one entry with out_last = 1.
- Comparison is signed over the full DATA_W. No width growth occurs.

## Timing
- Reset values: in_ready 1 in FILL, out_valid 0, out_data 0, out_index 0, out_last 0, count 0, state FILL, all entry valid bits 0.
- Insertion latency: 1 cycle. A sample accepted at edge N is reflected in count after edge N.
- Drain start: the in_last sample is accepted at edge N; out_valid goes high after edge N, holding the fully inserted head entry.
- Throughput: one entry per cycle while out_ready = 1.
- Backpressure: while out_ready = 0, out_valid, out_data, out_index and out_last hold stable.
- Return to FILL: in_ready goes high the cycle after the out_last handshake.
- No overlap: input and output never handshake in the same cycle.
- Reset asserted mid-frame or mid-drain clears everything immediately. The frame is lost and no partial out_last is issued.

## Configuration
- TOPK_RELU_EN defined: negative inputs are clamped to 0 before insertion, and out_data is never negative.
- TOPK_RELU_EN undefined: raw signed values are sorted and output unchanged.

## Structure
- Package topk_sort_pkg contains:
  - the state enum {FILL, DRAIN};
  - the packed entry struct {valid, data, index};
  - a compare function taking (a, b, asce) that returns "a ranks ahead of b".
- Sub-module topk_sort_cell is one array slot. Its inputs are its own entry, the previous slot's entry, the new sample and the previous slot's insert flag; it outputs the next entry and its own insert flag.
- Top level contains the DEPTH-instance generate chain, the FSM, the count register and the drain shifter.

## Test plan
- DEPTH=4, asce=1, inputs 20,15,25,5,2,10,35 (idx 0–6), last on 35 -> out 2/4, 5/3, 10/5, 15/1; out_last on 15/1.
- DEPTH=4, asce=0, same inputs -> out 35/6, 25/2, 20/0, 15/1.
- TOPK_RELU_EN, DEPTH=4, asce=0, inputs −3, 7, −1 (idx 0, 1, 2), last on −1 -> out 7/1, 0/0, 0/2 (stable tie); count = 3; out_last on 0/2.
- Backpressure: out_ready held low 5 cycles during drain -> out_data/out_index unchanged, no entry lost; in_ready stays 0 until the out_last handshake.
- Short frame: DEPTH=8, inputs 13, 11 (idx 7, 8), asce=1 -> out 11/8, then 13/7 with out_last; in_ready returns 1 the next cycle.
- Reset pulse after two of four drain handshakes -> out_valid 0, count 0, in_ready 1. A new frame 9 (idx 13, last) then drains 9/13 with out_last.
